// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM states and status-register layout for the SPI flash slave.
package spi_flash_pkg;

   localparam logic [7:0] CmdRead        = 8'h03;
   localparam logic [7:0] CmdProgram     = 8'h02;
   localparam logic [7:0] CmdSectorErase = 8'h20;
   localparam logic [7:0] CmdRdsr        = 8'h05;
   localparam logic [7:0] CmdRdid        = 8'h9F;
   localparam logic [7:0] CmdWren        = 8'h06;
   localparam logic [7:0] CmdWrdi        = 8'h04;

   localparam int unsigned StatusBusyBit = 0;
   localparam int unsigned StatusWelBit  = 1;

   typedef enum logic [2:0] {
      StIdle, StCmd, StAddr, StRdData, StWrData, StStatus, StId, StIgnore
   } state_e;

   // Index 3 and beyond reads as 0x00 once the ID bytes are exhausted.
   function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
      case (idx)
         2'd0:    return id[23:16];
         2'd1:    return id[15:8];
         2'd2:    return id[7:0];
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/spi_flash_slave_spi_pin_sync.sv
// Synchronizes SCK/CS/MOSI into i_clk and produces registered edge pulses.
module spi_pin_sync #(
   parameter int unsigned P_SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_spi_clk,
   input  logic i_spi_cs,
   input  logic i_spi_mosi,
   output logic o_sck_rise,
   output logic o_sck_fall,
   output logic o_cs_rise,
   output logic o_cs_fall,
   output logic o_cs,
   output logic o_mosi
);

   logic [P_SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
   logic                     r_sck_prev, r_cs_prev;

   // CS chain resets low so a transfer already in progress cannot look like a fresh CS fall.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sck_sync  <= '0;
         r_cs_sync   <= '0;
         r_mosi_sync <= '0;
         r_sck_prev  <= 1'b0;
         r_cs_prev   <= 1'b0;
         o_sck_rise  <= 1'b0;
         o_sck_fall  <= 1'b0;
         o_cs_rise   <= 1'b0;
         o_cs_fall   <= 1'b0;
         o_cs        <= 1'b0;
         o_mosi      <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[P_SYNC_STAGES-2:0], i_spi_clk};
         r_cs_sync   <= {r_cs_sync[P_SYNC_STAGES-2:0], i_spi_cs};
         r_mosi_sync <= {r_mosi_sync[P_SYNC_STAGES-2:0], i_spi_mosi};
         r_sck_prev  <= r_sck_sync[P_SYNC_STAGES-1];
         r_cs_prev   <= r_cs_sync[P_SYNC_STAGES-1];
         o_sck_rise  <= r_sck_sync[P_SYNC_STAGES-1] & ~r_sck_prev;
         o_sck_fall  <= ~r_sck_sync[P_SYNC_STAGES-1] & r_sck_prev;
         o_cs_rise   <= r_cs_sync[P_SYNC_STAGES-1] & ~r_cs_prev;
         o_cs_fall   <= ~r_cs_sync[P_SYNC_STAGES-1] & r_cs_prev;
         o_cs        <= r_cs_sync[P_SYNC_STAGES-1];
         o_mosi      <= r_mosi_sync[P_SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/spi_flash_slave.sv
// SPI mode-0 NOR flash emulator: command/address decode, MISO shifter and storage port strobes.
module spi_flash_slave
   import spi_flash_pkg::*;
#(
   parameter int unsigned P_ADDR_WIDTH  = 24,
   parameter logic [23:0] P_JEDEC_ID    = 24'hEF4017,
   parameter int unsigned P_SYNC_STAGES = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_spi_clk,
   input  logic                    i_spi_cs,
   input  logic                    i_spi_mosi,
   output logic                    o_spi_miso,
   output logic                    o_rd_req,
   output logic [P_ADDR_WIDTH-1:0] o_rd_addr,
   input  logic [7:0]              i_rd_data,
   output logic                    o_wr_valid,
   output logic [P_ADDR_WIDTH-1:0] o_wr_addr,
   output logic [7:0]              o_wr_data,
   output logic                    o_erase_valid,
   input  logic                    i_busy
);

   localparam int unsigned LP_ACW = $clog2(P_ADDR_WIDTH);

   logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_cs, w_mosi;
   logic [7:0]              w_byte_in, w_load_byte;
   logic [P_ADDR_WIDTH-1:0] w_addr_next;
   logic                    w_data_state;

   state_e                  r_state;
   logic [2:0]              r_bit_cnt;
   logic [6:0]              r_shift_in;
   logic [7:0]              r_cmd, r_shift_out, r_rd_buf;
   logic [P_ADDR_WIDTH-1:0] r_addr;
   logic [LP_ACW-1:0]       r_addr_cnt;
   logic [1:0]              r_id_idx, r_rd_dly;
   logic                    r_wel, r_erase_pend;

   spi_pin_sync #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_pin_sync (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_spi_clk  (i_spi_clk),
      .i_spi_cs   (i_spi_cs),
      .i_spi_mosi (i_spi_mosi),
      .o_sck_rise (w_sck_rise),
      .o_sck_fall (w_sck_fall),
      .o_cs_rise  (w_cs_rise),
      .o_cs_fall  (w_cs_fall),
      .o_cs       (w_cs),
      .o_mosi     (w_mosi)
   );

   assign w_byte_in    = {r_shift_in, w_mosi};
   assign w_addr_next  = {r_addr[P_ADDR_WIDTH-2:0], w_mosi};
   assign w_data_state = (r_state == StRdData) || (r_state == StStatus) || (r_state == StId);

   // Byte presented on MISO at the start of each returned byte.
   always_comb begin
      w_load_byte = 8'h00;
      case (r_state)
         StRdData: w_load_byte = r_rd_buf;
         StStatus: begin
            w_load_byte[StatusWelBit]  = r_wel;
            w_load_byte[StatusBusyBit] = i_busy;
         end
         StId:     w_load_byte = jedec_byte(P_JEDEC_ID, r_id_idx);
         default:  w_load_byte = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_bit_cnt     <= '0;
         r_shift_in    <= '0;
         r_cmd         <= '0;
         r_shift_out   <= '0;
         r_rd_buf      <= '0;
         r_addr        <= '0;
         r_addr_cnt    <= '0;
         r_id_idx      <= '0;
         r_rd_dly      <= '0;
         r_wel         <= 1'b0;
         r_erase_pend  <= 1'b0;
         o_spi_miso    <= 1'b0;
         o_rd_req      <= 1'b0;
         o_rd_addr     <= '0;
         o_wr_valid    <= 1'b0;
         o_wr_addr     <= '0;
         o_wr_data     <= '0;
         o_erase_valid <= 1'b0;
      end else begin
         o_rd_req      <= 1'b0;
         o_wr_valid    <= 1'b0;
         o_erase_valid <= 1'b0;
         r_rd_dly      <= {r_rd_dly[0], o_rd_req};
         if (r_rd_dly[1]) r_rd_buf <= i_rd_data;

         if (w_cs_rise) begin
            if (r_erase_pend && r_wel) o_erase_valid <= 1'b1;
            if (r_cmd == CmdProgram || r_cmd == CmdSectorErase) r_wel <= 1'b0;
         end

         if (w_cs || w_cs_rise) begin
            r_state      <= StIdle;
            r_bit_cnt    <= '0;
            r_shift_in   <= '0;
            r_shift_out  <= '0;
            r_erase_pend <= 1'b0;
            o_spi_miso   <= 1'b0;
         end else if (r_state == StIdle) begin
            if (w_cs_fall) begin
               r_state   <= StCmd;
               r_bit_cnt <= '0;
               r_cmd     <= '0;
            end
         end else begin
            if (w_sck_fall) begin
               if (!w_data_state) begin
                  o_spi_miso <= 1'b0;
               end else if (r_bit_cnt == 3'd0) begin
                  o_spi_miso  <= w_load_byte[7];
                  r_shift_out <= {w_load_byte[6:0], 1'b0};
                  if (r_state == StId && r_id_idx != 2'd3) r_id_idx <= r_id_idx + 2'd1;
               end else begin
                  o_spi_miso  <= r_shift_out[7];
                  r_shift_out <= {r_shift_out[6:0], 1'b0};
               end
            end

            if (w_sck_rise) begin
               r_bit_cnt    <= r_bit_cnt + 3'd1;
               r_shift_in   <= w_byte_in[6:0];
               r_erase_pend <= 1'b0;
               case (r_state)
                  StCmd: if (r_bit_cnt == 3'd7) begin
                     r_cmd      <= w_byte_in;
                     r_addr_cnt <= '0;
                     r_id_idx   <= '0;
                     case (w_byte_in)
                        CmdRead, CmdProgram, CmdSectorErase: r_state <= StAddr;
                        CmdRdsr: r_state <= StStatus;
                        CmdRdid: r_state <= StId;
                        CmdWren: begin r_wel <= 1'b1; r_state <= StIgnore; end
                        CmdWrdi: begin r_wel <= 1'b0; r_state <= StIgnore; end
                        default: r_state <= StIgnore;
                     endcase
                  end
                  StAddr: begin
                     r_addr     <= w_addr_next;
                     r_addr_cnt <= r_addr_cnt + LP_ACW'(1);
                     if (r_addr_cnt == LP_ACW'(P_ADDR_WIDTH - 1)) begin
                        case (r_cmd)
                           CmdRead: begin
                              o_rd_req  <= 1'b1;
                              o_rd_addr <= w_addr_next;
                              r_state   <= StRdData;
                           end
                           CmdProgram: r_state <= StWrData;
                           default: begin
                              o_wr_addr    <= w_addr_next;
                              r_erase_pend <= 1'b1;
                              r_state      <= StIgnore;
                           end
                        endcase
                     end
                  end
                  // Prefetch the next byte while the current one is still shifting out.
                  StRdData: if (r_bit_cnt == 3'd0) begin
                     o_rd_req  <= 1'b1;
                     o_rd_addr <= o_rd_addr + P_ADDR_WIDTH'(1);
                  end
                  StWrData: if (r_bit_cnt == 3'd7 && r_wel) begin
                     o_wr_valid  <= 1'b1;
                     o_wr_addr   <= r_addr;
                     o_wr_data   <= w_byte_in;
                     r_addr[7:0] <= r_addr[7:0] + 8'd1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed bench: drives SPI transactions and checks MISO bytes and storage-port strobes.
module tb_spi_flash_slave;

   localparam int unsigned AW   = 24;
   localparam int          HALF = 80;

   logic          clk = 1'b0, rst = 1'b1, sck = 1'b0, cs = 1'b1, mosi = 1'b0, busy = 1'b0;
   logic          miso, rd_req, wr_valid, erase_valid;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [7:0]    wr_data;
   logic [7:0]    rd_data = 8'hEE;

   int            n_checks = 0, n_fail = 0;
   logic [31:0]   rd_log[$], wr_log[$], er_log[$];
   logic [AW-1:0] rd_addr_q;
   int            rd_wait = 0;
   logic [7:0]    rx;
   int            n_rd0, n_wr0, n_er0;

   spi_flash_slave #(.P_ADDR_WIDTH(AW), .P_JEDEC_ID(24'hEF4017), .P_SYNC_STAGES(2)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_spi_clk     (sck),
      .i_spi_cs      (cs),
      .i_spi_mosi    (mosi),
      .o_spi_miso    (miso),
      .o_rd_req      (rd_req),
      .o_rd_addr     (rd_addr),
      .i_rd_data     (rd_data),
      .o_wr_valid    (wr_valid),
      .o_wr_addr     (wr_addr),
      .o_wr_data     (wr_data),
      .o_erase_valid (erase_valid),
      .i_busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_read(input logic [AW-1:0] a);
      case (a)
         24'h000000: return 8'h5A;
         24'h0000FE: return 8'hA5;
         24'h0000FF: return 8'h3C;
         24'h000100: return 8'h81;
         default:    return 8'h00;
      endcase
   endfunction

   // Storage model: data valid only in the cycle two after the request, junk otherwise.
   always @(negedge clk) begin
      rd_data = 8'hEE;
      if (rd_wait == 1) rd_data = mem_read(rd_addr_q);
      if (rd_wait != 0) rd_wait = rd_wait - 1;
      if (rd_req) begin
         rd_addr_q = rd_addr;
         rd_wait   = 2;
         rd_log.push_back(32'(rd_addr));
      end
      if (wr_valid)    wr_log.push_back({wr_addr, wr_data});
      if (erase_valid) er_log.push_back(32'(wr_addr));
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
      r = '0;
      for (int i = 0; i < n; i++) begin
         mosi = tx[7-i];
         #(HALF);
         r = {r[6:0], miso};
         sck = 1'b1;
         #(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] tx);
      logic [7:0] r;
      spi_bits(tx, 8, r);
   endtask

   task automatic send_addr(input logic [23:0] a);
      send(a[23:16]);
      send(a[15:8]);
      send(a[7:0]);
   endtask

   task automatic spi_start;
      cs = 1'b0;
      #(HALF);
   endtask

   task automatic spi_stop;
      #(HALF);
      cs = 1'b1;
      #(4 * HALF);
   endtask

   task automatic one_byte_cmd(input logic [7:0] c);
      spi_start(); send(c); spi_stop();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #23;
      check("rst_miso", 32'(miso), 0);
      check("rst_strobes", {29'd0, rd_req, wr_valid, erase_valid}, 0);
      check("rst_rd_addr", 32'(rd_addr), 0);
      check("rst_wr_bus", {wr_addr, wr_data}, 0);
      rst = 1'b0;
      #(4 * HALF);

      // READ across the 0xFF -> 0x100 boundary
      spi_start(); send(8'h03); send_addr(24'h0000FE);
      spi_bits(8'h00, 8, rx); check("read_b0", 32'(rx), 32'hA5);
      spi_bits(8'h00, 8, rx); check("read_b1", 32'(rx), 32'h3C);
      spi_bits(8'h00, 8, rx); check("read_b2", 32'(rx), 32'h81);
      spi_stop();
      check("read_req0", rd_log.size() > 0 ? rd_log[0] : 32'hFFFF_FFFF, 32'h0000FE);
      check("read_req1", rd_log.size() > 1 ? rd_log[1] : 32'hFFFF_FFFF, 32'h0000FF);
      check("read_req2", rd_log.size() > 2 ? rd_log[2] : 32'hFFFF_FFFF, 32'h000100);

      // WREN sets WEL visible in status
      one_byte_cmd(8'h06);
      spi_start(); send(8'h05); spi_bits(8'h00, 8, rx); spi_stop();
      check("rdsr_wel", 32'(rx), 32'h02);

      // PROGRAM with page wrap; WEL clears afterwards
      spi_start(); send(8'h02); send_addr(24'h0012FF); send(8'h11); send(8'h22); spi_stop();
      check("prog_n", 32'(wr_log.size()), 2);
      check("prog_w0", wr_log.size() > 0 ? wr_log[0] : 32'hFFFF_FFFF, 32'h0012FF11);
      check("prog_w1", wr_log.size() > 1 ? wr_log[1] : 32'hFFFF_FFFF, 32'h00120022);
      spi_start(); send(8'h05); spi_bits(8'h00, 8, rx); spi_stop();
      check("rdsr_after_prog", 32'(rx), 32'h00);

      // PROGRAM without WREN is discarded; busy reported in bit 0
      spi_start(); send(8'h02); send_addr(24'h000010); send(8'h55); spi_stop();
      check("prog_nowel_n", 32'(wr_log.size()), 2);
      busy = 1'b1;
      spi_start(); send(8'h05); spi_bits(8'h00, 8, rx); spi_bits(8'h00, 8, rx); spi_stop();
      check("rdsr_busy", 32'(rx), 32'h01);
      busy = 1'b0;

      // SECTOR_ERASE, then a truncated erase
      one_byte_cmd(8'h06);
      spi_start(); send(8'h20); send_addr(24'h001000); spi_stop();
      check("erase_n", 32'(er_log.size()), 1);
      check("erase_addr", er_log.size() > 0 ? er_log[0] : 32'hFFFF_FFFF, 32'h001000);
      one_byte_cmd(8'h06);
      spi_start(); send(8'h20); send(8'h00); spi_stop();
      check("erase_short_n", 32'(er_log.size()), 1);
      spi_start(); send(8'h05); spi_bits(8'h00, 8, rx); spi_stop();
      check("rdsr_after_short_erase", 32'(rx), 32'h00);

      // RDID then trailing zeros
      spi_start(); send(8'h9F);
      spi_bits(8'h00, 8, rx); check("id0", 32'(rx), 32'hEF);
      spi_bits(8'h00, 8, rx); check("id1", 32'(rx), 32'h40);
      spi_bits(8'h00, 8, rx); check("id2", 32'(rx), 32'h17);
      spi_bits(8'h00, 8, rx); check("id3", 32'(rx), 32'h00);
      spi_stop();

      // Unknown opcode
      n_rd0 = rd_log.size(); n_wr0 = wr_log.size(); n_er0 = er_log.size();
      spi_start(); send(8'hAB);
      spi_bits(8'hFF, 8, rx); check("unk_b0", 32'(rx), 0);
      spi_bits(8'hFF, 8, rx); check("unk_b1", 32'(rx), 0);
      spi_stop();
      check("unk_strobes", {rd_log.size(), wr_log.size(), er_log.size()} , {n_rd0, n_wr0, n_er0});

      // CS rise partway through a program data byte
      one_byte_cmd(8'h06);
      spi_start(); send(8'h02); send_addr(24'h000020); spi_bits(8'hFF, 4, rx); spi_stop();
      check("prog_partial_n", 32'(wr_log.size()), 2);

      // Async reset mid-READ, stray clocks ignored, then a clean READ
      spi_start(); send(8'h03); send_addr(24'h0000FE);
      #60;
      check("pre_rst_miso", 32'(miso), 1);
      rst = 1'b1;
      #1;
      check("midrst_miso", 32'(miso), 0);
      check("midrst_rd_addr", 32'(rd_addr), 0);
      #50;
      rst = 1'b0;
      #50;
      n_rd0 = rd_log.size();
      spi_bits(8'h03, 8, rx);
      check("stray_miso", 32'(rx), 0);
      check("stray_rd_n", 32'(rd_log.size()), 32'(n_rd0));
      spi_stop();
      spi_start(); send(8'h03); send_addr(24'h000000);
      spi_bits(8'h00, 8, rx); check("read_after_rst", 32'(rx), 32'h5A);
      spi_stop();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_flash_slave.md
# spi_flash_slave

SPI mode-0 slave that responds to the team's SPI flash master from the flash side. It sits on an FPGA or emulation board posing as a NOR flash device. It oversamples SCK/CS/MOSI in its own i_clk domain and decodes a 1-byte command plus an optional 24-bit address. It returns read/status/ID bytes on MISO and hands program, erase and read accesses to a user storage port with fixed 2-cycle read latency.

## Interface
- P_ADDR_WIDTH, 24, address bits received after command (multiple of 8)
- P_JEDEC_ID, 24'hEF4017, bytes returned by RDID, MSB byte first
- P_SYNC_STAGES, 2, synchronizer depth on SCK/CS/MOSI (≥2)
- i_clk  in  1  system clock; reset i_rst, asynchronous, active-high; clock i_clk
- i_rst  in  1  asynchronous active-high reset
- i_spi_clk  in  1  SCK from master, CPOL=0
- i_spi_cs  in  1  chip select, active low
- i_spi_mosi  in  1  serial data in, MSB first
- o_spi_miso  out  1  serial data out, MSB first; 0 when deselected
- o_rd_req  out  1  one-cycle read request to storage
- o_rd_addr  out  P_ADDR_WIDTH  read address, valid with o_rd_req
- i_rd_data  in  8  storage data, sampled exactly 2 cycles after o_rd_req
- o_wr_valid  out  1  one-cycle program-byte strobe
- o_wr_addr  out  P_ADDR_WIDTH  program address
- o_wr_data  out  8  program byte
- o_erase_valid  out  1  one-cycle sector-erase strobe, address on o_wr_addr
- i_busy  in  1  storage busy, reported as status bit 0

## Operation
- Requirements: i_clk ≥ 8× SCK. SCK, CS and MOSI pass through P_SYNC_STAGES flops. Edges are detected on the synchronized SCK; MOSI is sampled on the rise, MISO is updated on the fall.
- Bit counter 0–7 within a byte. CS rising, or CS high in any state, returns to IDLE, clears the bit counter and drops the partial byte.
- States:
  - IDLE: CS falls → CMD.
  - CMD: after 8 bits, decode:
    - 0x03 READ → ADDR
    - 0x02 PROGRAM → ADDR
    - 0x20 SECTOR_ERASE → ADDR
    - 0x05 RDSR → STATUS
    - 0x9F RDID → ID
    - 0x06 WREN: set WEL → IGNORE
    - 0x04 WRDI: clear WEL → IGNORE
    - anything else → IGNORE
  - ADDR: shift P_ADDR_WIDTH bits. On the last rising edge, READ issues o_rd_req with the received address and goes to RD_DATA; PROGRAM goes to WR_DATA; ERASE goes to IGNORE with an erase pending.
  - RD_DATA: load i_rd_data into the shift register; drive bit 7 on the next SCK fall. The 8th falling edge of each byte clocks out the last bit. At the 1st rising edge of the following byte, o_rd_req fires at addr+1. The address wraps at 2^P_ADDR_WIDTH.
  - WR_DATA: every 8 received bits, if WEL=1, pulse o_wr_valid with the byte at the current address. Increment only the low 8 address bits (256-byte page wrap). If WEL=0, discard bytes.
  - STATUS: repeatedly return {6'b0, WEL, i_busy}; i_busy is sampled at each byte start.
  - ID: return the 3 bytes of P_JEDEC_ID, then 0x00 until deselect.
  - IGNORE: MISO=0, no strobes.
- Erase: at CS rise, pulse o_erase_valid only if WEL=1 and exactly 8+P_ADDR_WIDTH bits were received.
- WEL clears at the CS rise that ends any PROGRAM or ERASE command, whether or not that command took effect.

## Timing
- Reset values: o_spi_miso=0, o_rd_req=0, o_rd_addr=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_erase_valid=0, WEL=0, state IDLE.
- Edge-detect latency is P_SYNC_STAGES+1 cycles from the pin. o_rd_req goes out 1 cycle after the detected rise. i_rd_data is captured at req+2, which is before the earliest detected fall (≥4 cycles later).
- o_wr_valid asserts 1 cycle after the 8th detected rise of a data byte.
- o_erase_valid asserts 1 cycle after CS-rise detection.
- CS rising mid-byte: no strobe for that byte; o_spi_miso is forced to 0 in the next cycle.
- Async reset mid-transfer: all outputs return to reset values immediately. The next transfer must start with a fresh CS fall; a transfer already in progress is ignored until CS goes high.

## Structure
- Shared package spi_flash_pkg: command opcodes (0x03, 0x02, 0x20, 0x05, 0x9F, 0x06, 0x04), state enum, status bit positions.
- One natural sub-module, spi_pin_sync: synchronizer plus SCK rise/fall and CS rise/fall detect.
- FSM, shift registers and address counter stay in the top module.

## Test plan
- READ 0x03, addr 0x0000FE, 3 bytes from model memory {0xFE:0xA5, 0xFF:0x3C, 0x100:0x81} → MISO bytes A5, 3C, 81; o_rd_addr sequence 0xFE, 0xFF, 0x100.
- WREN, then PROGRAM 0x02 at addr 0x0012FF with bytes 0x11, 0x22 → o_wr_valid at 0x12FF/0x11, then 0x1200/0x22 (page wrap). A following RDSR returns 0x00.
- PROGRAM without WREN at 0x000010, byte 0x55 → no o_wr_valid; RDSR with i_busy=1 → 0x01.
- WREN, then SECTOR_ERASE 0x20 at addr 0x001000 → a single o_erase_valid with o_wr_addr=0x001000 after CS rise. Repeating the erase with CS raised after 16 bits gives no strobe.
- RDID → EF, 40, 17, 00. Unknown opcode 0xAB → MISO stays 0, no strobes.
- Raise CS after 4 bits of a program data byte → no o_wr_valid. Assert i_rst during a READ → o_spi_miso=0 at once; the next READ at 0x000000 returns memory[0].
